// File: rtl/data_ram_if.sv
// ---------------------------------------------------------------------------
// data_ram_if
//   Bundles the CPU core's ram_* data-memory port in one place.
//
//   Signals (named from the memory's point of view):
//     ce_i    access enable
//     we_i    1 = write, 0 = read
//     addr_i  byte address; bits [1:0] are ignored
//     sel_i   byte-lane enables; sel_i[k] covers data bits [8k+7:8k]
//     data_i  write data
//     data_o  combinational read data
//
//   Handshake: ce_i acts as "valid". There is no ready signal. Every access
//   presented while the memory is out of its init sweep is taken on the
//   rising clk edge of the same cycle. While busy_o is high the core is held
//   in reset, and any access that shows up anyway is ignored.
//
//   Modports:
//     master  the core side, which drives the request and samples data_o
//     slave   the memory side
// ---------------------------------------------------------------------------
interface data_ram_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce_i,
        output we_i,
        output addr_i,
        output sel_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  ce_i,
        input  we_i,
        input  addr_i,
        input  sel_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
//   Data-memory responder for the CPU core's ram_* port. It services one
//   word access per cycle:
//     - reads are combinational, with zero latency;
//     - writes use byte lanes and commit on the rising edge of clk.
//   After reset, an init FSM writes zero to every word. busy_o stays high
//   during this sweep, which keeps the core in reset. The block also keeps
//   read/write access counters and a sticky out-of-range error status for
//   debug.
//
//   Optional feature: define DRAM_MMIO_EN to decode two MMIO words.
//     MMIO_BASE + 0  LED register. Writes update lanes sel_i[1:0].
//                    Reads return {16'h0, led_o}.
//     MMIO_BASE + 4  Free-running cycle counter. Read-only; writes are
//                    ignored.
//   If DRAM_MMIO_EN is undefined, both addresses are ordinary out-of-range
//   errors and led_o is tied to 0.
//
//   Parameters:
//     ADDR_W     word-address bits; depth is 2**ADDR_W words of 32 bits
//     MMIO_BASE  base address of the MMIO window (DRAM_MMIO_EN only)
//
//   Ports:
//     clk         clock; all state changes on the rising edge
//     rst         asynchronous, active-low reset
//     bus         data_ram_if.slave (ce_i/we_i/addr_i/sel_i/data_i/data_o)
//     busy_o      1 while the init sweep runs
//     err_o       sticky out-of-range access flag
//     err_addr_o  addr_i of the access that first set err_o
//     err_clr_i   one-cycle pulse; clears err_o and err_addr_o
//     rd_cnt_o    completed in-range reads; wraps at 2**32
//     wr_cnt_o    completed in-range writes; wraps at 2**32
//     led_o       MMIO LED register
//     state_o     FSM state for debug (0 = INIT, 1 = READY)
// ---------------------------------------------------------------------------
module data_ram #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    data_ram_if.slave   bus,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic [15:0] led_o,
    output logic        state_o
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [31:0]       mem [DEPTH];

    logic              ready;
    logic              in_range;
    logic              is_led;
    logic              is_cyc;
    logic              is_mmio;
    logic              mem_rd;
    logic              mem_wr;
    logic              err_hit;
    logic [ADDR_W-1:0] word_idx;

    // ------------------------------------------------------------------
    // Init FSM: the state register and idx. The idx keeps counting while
    // the FSM is in INIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // INIT zeroes one word per cycle. The last word is written in the same
    // cycle that moves the FSM to READY, so INIT lasts exactly DEPTH cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign ready   = (state_q == ST_READY);
    assign busy_o  = ~ready;
    assign state_o = state_q;

    // ------------------------------------------------------------------
    // Address decode. An address is in range when every bit above the
    // word index is 0. When the feature is enabled, the MMIO words take
    // priority over the memory decode.
    // ------------------------------------------------------------------
    assign word_idx = bus.addr_i[ADDR_W+1:2];
    assign in_range = ((bus.addr_i >> (ADDR_W + 2)) == 32'd0);

`ifdef DRAM_MMIO_EN
    localparam logic [29:0] LED_WA = MMIO_BASE[31:2];
    localparam logic [29:0] CYC_WA = LED_WA + 30'd1;

    assign is_led = (bus.addr_i[31:2] == LED_WA);
    assign is_cyc = (bus.addr_i[31:2] == CYC_WA);
`else
    assign is_led = 1'b0;
    assign is_cyc = 1'b0;
`endif

    assign is_mmio = is_led | is_cyc;
    assign mem_rd  = ready & bus.ce_i & ~bus.we_i & in_range & ~is_mmio;
    assign mem_wr  = ready & bus.ce_i &  bus.we_i & in_range & ~is_mmio;
    assign err_hit = ready & bus.ce_i & ~in_range & ~is_mmio;

    // ------------------------------------------------------------------
    // Storage. The array is never reset directly; the init sweep is what
    // clears it. The INIT write overrides the core port, which the core
    // cannot use while busy_o is high anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[idx_q] <= '0;
        end else if (mem_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.sel_i[k]) begin
                    mem[word_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
                end
            end
        end
    end

`ifdef DRAM_MMIO_EN
    // ------------------------------------------------------------------
    // MMIO registers. The cycle counter also runs during INIT, so reads
    // of it taken N cycles apart always differ by N.
    // ------------------------------------------------------------------
    logic [15:0] led_q;
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (ready && bus.ce_i && bus.we_i && is_led) begin
                if (bus.sel_i[0]) led_q[7:0]  <= bus.data_i[7:0];
                if (bus.sel_i[1]) led_q[15:8] <= bus.data_i[15:8];
            end
        end
    end

    assign led_o = led_q;
`else
    assign led_o = '0;
`endif

    // ------------------------------------------------------------------
    // Read data. This is 0 unless a read is being served this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.data_o = '0;
        if (mem_rd) begin
            bus.data_o = mem[word_idx];
        end
`ifdef DRAM_MMIO_EN
        else if (ready && bus.ce_i && !bus.we_i && is_led) begin
            bus.data_o = {16'h0, led_q};
        end else if (ready && bus.ce_i && !bus.we_i && is_cyc) begin
            bus.data_o = cyc_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Access counters. Only in-range memory accesses are counted.
    // A write with sel_i == 0 still counts as a write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            if (mem_rd) rd_cnt_o <= rd_cnt_o + 32'd1;
            if (mem_wr) wr_cnt_o <= wr_cnt_o + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error. Only the first error address is kept. If a clear
    // arrives in the same cycle as a new error, the clear acts first and
    // the new error then sets the flag, so the new address is recorded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (err_hit && (!err_o || err_clr_i)) begin
            err_o      <= 1'b1;
            err_addr_o <= bus.addr_i;
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end
    end

    // The byte-offset bits and the MMIO base are not needed in every build.
    logic unused_bits;
    assign unused_bits = ^{bus.addr_i[1:0], MMIO_BASE};

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;
    localparam int          ADDR_W    = 4;
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_ram_if bus ();

    logic        busy_o, err_o, err_clr_i, state_o;
    logic [31:0] err_addr_o, rd_cnt_o, wr_cnt_o;
    logic [15:0] led_o;

    data_ram #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o),
        .err_clr_i  (err_clr_i),
        .rd_cnt_o   (rd_cnt_o),
        .wr_cnt_o   (wr_cnt_o),
        .led_o      (led_o),
        .state_o    (state_o)
    );

    // scoreboard
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model[DEPTH];
    logic [31:0] exp_rd = 0;
    logic [31:0] exp_wr = 0;

    function automatic logic tb_in_range(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) == 32'd0;
    endfunction

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic idle();
        bus.ce_i   = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = '0;
        bus.sel_i  = '0;
        bus.data_i = '0;
        err_clr_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
        if (tb_in_range(a)) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) model[a[ADDR_W+1:2]][8*k +: 8] = d[8*k +: 8];
            exp_wr = exp_wr + 1;
        end
        @(posedge clk); #1;
        idle();
    endtask

    // read with expectation pushed to the scoreboard at drive time
    task automatic rd(input logic [31:0] a, output logic [31:0] got);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.sel_i = 4'h0;
        if (tb_in_range(a)) begin
            exp_q.push_back(model[a[ADDR_W+1:2]]);
            exp_rd = exp_rd + 1;
        end else begin
            exp_q.push_back(32'h0);
        end
        @(negedge clk);
        got = bus.data_o;
        @(posedge clk); #1;
        idle();
    endtask

    // read without scoreboard entry (MMIO values)
    task automatic rd_raw(input logic [31:0] a, output logic [31:0] got);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.sel_i = 4'h0;
        @(negedge clk);
        got = bus.data_o;
        @(posedge clk); #1;
        idle();
    endtask

    // Release rst and count cycles with busy_o high. An access is driven the
    // whole time; it must be ignored.
    task automatic release_and_count(input logic wr_during, output int busy_n, output int data_nz);
        busy_n  = 0;
        data_nz = 0;
        bus.ce_i = 1'b1; bus.we_i = wr_during; bus.addr_i = 32'h8;
        bus.sel_i = 4'hF; bus.data_i = 32'hFFFF_FFFF;
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            busy_n++;
            if (bus.data_o !== 32'h0) data_nz++;
        end
        idle();
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        int bn, nz;
        idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%0b exp=1", busy_o); end
        n_cmp++; if (state_o !== 1'b0) begin n_bad++; $display("FAIL reset_state got=%0b exp=0", state_o); end
        n_cmp++; if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_err got=%0b/%h exp=0/0", err_o, err_addr_o); end
        n_cmp++; if (rd_cnt_o !== 32'h0 || wr_cnt_o !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", rd_cnt_o, wr_cnt_o); end
        n_cmp++; if (led_o !== 16'h0) begin n_bad++; $display("FAIL reset_led got=%h exp=0", led_o); end
        release_and_count(1'b0, bn, nz);
        n_cmp++; if (bn !== DEPTH) begin n_bad++; $display("FAIL init_len got=%0d exp=%0d", bn, DEPTH); end
        n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL init_data_o got=%0d nonzero exp=0", nz); end
        n_cmp++; if (state_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL ready_state got=%0b/%0b exp=1/0", state_o, busy_o); end
        n_cmp++; if (rd_cnt_o !== 32'h0) begin n_bad++; $display("FAIL init_rd_cnt got=%0d exp=0", rd_cnt_o); end
    endtask

    task automatic test_init_zero();
        logic [31:0] got, exp;
        for (int i = 0; i < DEPTH; i++) begin
            rd(32'(i * 4), got);
            exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL init_zero[%0d] got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_lane_write();
        logic [31:0] got, exp;
        wr(32'h8, 4'hF, 32'hDEAD_BEEF);
        wr(32'h8, 4'b0001, 32'h0000_0011);
        rd(32'h8, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp || got !== 32'hDEAD_BE11) begin n_bad++; $display("FAIL lane_write got=%h exp=%h", got, exp); end
        n_cmp++; if (wr_cnt_o !== exp_wr) begin n_bad++; $display("FAIL lane_wr_cnt got=%0d exp=%0d", wr_cnt_o, exp_wr); end
        n_cmp++; if (rd_cnt_o !== exp_rd) begin n_bad++; $display("FAIL lane_rd_cnt got=%0d exp=%0d", rd_cnt_o, exp_rd); end
        // sel=0 write counts but changes nothing
        wr(32'h8, 4'h0, 32'h1234_5678);
        rd(32'h8, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== 32'hDEAD_BE11 || got !== exp) begin n_bad++; $display("FAIL sel0_data got=%h exp=%h", got, exp); end
        n_cmp++; if (wr_cnt_o !== exp_wr) begin n_bad++; $display("FAIL sel0_wr_cnt got=%0d exp=%0d", wr_cnt_o, exp_wr); end
        // upper lanes only, last word
        wr(32'h3C, 4'hF, 32'h0102_0304);
        wr(32'h3C, 4'b1100, 32'hAABB_CCDD);
        rd(32'h3C, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== 32'hAABB_0304 || got !== exp) begin n_bad++; $display("FAIL lane_hi got=%h exp=AABB0304", got); end
    endtask

    task automatic test_ce_low();
        logic [31:0] got, exp;
        logic [31:0] rc, wc;
        rc = exp_rd; wc = exp_wr;
        bus.ce_i = 1'b0; bus.we_i = 1'b1; bus.addr_i = 32'h8; bus.sel_i = 4'hF; bus.data_i = 32'h0;
        @(negedge clk);
        n_cmp++; if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL ce_low_data got=%h exp=0", bus.data_o); end
        @(posedge clk); #1;
        idle();
        n_cmp++; if (rd_cnt_o !== rc || wr_cnt_o !== wc) begin n_bad++; $display("FAIL ce_low_cnt got=%0d/%0d exp=%0d/%0d", rd_cnt_o, wr_cnt_o, rc, wc); end
        rd(32'h8, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ce_low_mem got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp, a, d;
        logic [3:0]  s;
        int bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            wr(a, s, d);
            rd(a, got);
            exp = exp_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL b2b[%0d] addr=%h got=%h exp=%h", i, a, got, exp);
            end
            n_cmp++;
            if (got !== exp) n_bad++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(32'(i * 4), got);
            exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sweep[%0d] got=%h exp=%h", i, got, exp); end
        end
        n_cmp++; if (rd_cnt_o !== exp_rd || wr_cnt_o !== exp_wr) begin n_bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d", rd_cnt_o, wr_cnt_o, exp_rd, exp_wr); end
    endtask

    task automatic test_errors();
        logic [31:0] got, exp;
        wr(32'h0000_4000, 4'hF, 32'hFFFF_FFFF);
        n_cmp++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_4000) begin n_bad++; $display("FAIL err_set got=%0b/%h exp=1/00004000", err_o, err_addr_o); end
        n_cmp++; if (wr_cnt_o !== exp_wr) begin n_bad++; $display("FAIL err_wr_cnt got=%0d exp=%0d", wr_cnt_o, exp_wr); end
        rd(32'h0000_8000, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL err_rd_data got=%h exp=%h", got, exp); end
        n_cmp++; if (err_addr_o !== 32'h0000_4000) begin n_bad++; $display("FAIL err_sticky got=%h exp=00004000", err_addr_o); end
        n_cmp++; if (rd_cnt_o !== exp_rd) begin n_bad++; $display("FAIL err_rd_cnt got=%0d exp=%0d", rd_cnt_o, exp_rd); end
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        idle();
        n_cmp++; if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin n_bad++; $display("FAIL err_clr got=%0b/%h exp=0/0", err_o, err_addr_o); end
        // first word past the end of the array
        rd(32'h40, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp || err_o !== 1'b1 || err_addr_o !== 32'h40) begin n_bad++; $display("FAIL err_edge got=%h/%0b/%h exp=0/1/00000040", got, err_o, err_addr_o); end
        // clear together with a new error: the error wins
        err_clr_i = 1'b1;
        rd(32'h0001_0000, got);
        exp = exp_q.pop_front();
        n_cmp++; if (err_o !== 1'b1 || err_addr_o !== 32'h0001_0000) begin n_bad++; $display("FAIL err_clr_collide got=%0b/%h exp=1/00010000", err_o, err_addr_o); end
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        idle();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clr2 got=%0b exp=0", err_o); end
    endtask

    task automatic test_mmio();
        logic [31:0] got, t0, t1;
        logic [31:0] rc, wc;
        rc = exp_rd; wc = exp_wr;
`ifdef DRAM_MMIO_EN
        wr(MMIO_BASE, 4'h3, 32'h0000_A5A5);
        n_cmp++; if (led_o !== 16'hA5A5) begin n_bad++; $display("FAIL mmio_led got=%h exp=A5A5", led_o); end
        wr(MMIO_BASE, 4'b0010, 32'h0000_1234);
        n_cmp++; if (led_o !== 16'h12A5) begin n_bad++; $display("FAIL mmio_led_lane got=%h exp=12A5", led_o); end
        rd_raw(MMIO_BASE, got);
        n_cmp++; if (got !== 32'h0000_12A5) begin n_bad++; $display("FAIL mmio_led_rd got=%h exp=000012A5", got); end
        rd_raw(MMIO_BASE + 32'd4, t0);
        repeat (4) @(posedge clk);
        #1;
        rd_raw(MMIO_BASE + 32'd4, t1);
        n_cmp++; if (t1 - t0 !== 32'd5) begin n_bad++; $display("FAIL mmio_cyc got=%0d exp=5", t1 - t0); end
        wr(MMIO_BASE + 32'd4, 4'hF, 32'h0);
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mmio_no_err got=%0b exp=0", err_o); end
        n_cmp++; if (rd_cnt_o !== rc || wr_cnt_o !== wc) begin n_bad++; $display("FAIL mmio_cnt got=%0d/%0d exp=%0d/%0d", rd_cnt_o, wr_cnt_o, rc, wc); end
`else
        wr(MMIO_BASE, 4'h3, 32'h0000_A5A5);
        n_cmp++; if (err_o !== 1'b1 || err_addr_o !== MMIO_BASE) begin n_bad++; $display("FAIL mmio_off_err got=%0b/%h exp=1/%h", err_o, err_addr_o, MMIO_BASE); end
        n_cmp++; if (led_o !== 16'h0) begin n_bad++; $display("FAIL mmio_off_led got=%h exp=0", led_o); end
        rd_raw(MMIO_BASE + 32'd4, got);
        n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL mmio_off_rd got=%h exp=0", got); end
        n_cmp++; if (rd_cnt_o !== rc || wr_cnt_o !== wc) begin n_bad++; $display("FAIL mmio_off_cnt got=%0d/%0d exp=%0d/%0d", rd_cnt_o, wr_cnt_o, rc, wc); end
`endif
    endtask

    task automatic test_reset_mid_init();
        int bn, nz;
        logic [31:0] got, exp;
        // leave an error set so the reset has something to clear
        wr(32'h0000_4000, 4'hF, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (busy_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_async got=%0b/%0b exp=1/0", busy_o, err_o); end
        n_cmp++; if (rd_cnt_o !== 32'h0 || wr_cnt_o !== 32'h0) begin n_bad++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", rd_cnt_o, wr_cnt_o); end
        @(posedge clk); #1;
        exp_rd = 0; exp_wr = 0;
        release_and_count(1'b1, bn, nz);
        n_cmp++; if (bn !== DEPTH) begin n_bad++; $display("FAIL mid_rst_len got=%0d exp=%0d", bn, DEPTH); end
        n_cmp++; if (wr_cnt_o !== 32'h0 || err_o !== 1'b0) begin n_bad++; $display("FAIL init_ignore got=%0d/%0b exp=0/0", wr_cnt_o, err_o); end
        n_cmp++; if (led_o !== 16'h0) begin n_bad++; $display("FAIL mid_rst_led got=%h exp=0", led_o); end
        rd(32'h8, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mid_rst_mem got=%h exp=%h", got, exp); end
        rd(32'h3C, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mid_rst_mem_last got=%h exp=%h", got, exp); end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_zero();
        test_lane_write();
        test_ce_low();
        test_back_to_back();
        test_errors();
        test_mmio();
        test_reset_mid_init();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
